// File: rtl/chk_frame_seq_pkg.sv
// Shared constants and state encoding for the 15-bit check-register frame sequencer.
package chk_frame_seq_pkg;

    localparam int CHK_W   = 15;
    localparam int FRAME_N = 64;
    localparam int MSG_K   = 40;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/chk_shift15.sv
// 15-bit check register: rotates toward bit 0, with the incoming bit folded into the top.
module chk_shift15
    import chk_frame_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift,
    input  logic             data_in,
    output logic [CHK_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift) begin
            q <= {data_in ^ q[0], q[CHK_W-1:1]};
        end
    end

endmodule

// File: rtl/chk_frame_seq.sv
// Frame sequencer: collects N serial bits into the check register and offers the
// final check value on a valid/ready result port.
module chk_frame_seq
    import chk_frame_seq_pkg::*;
#(
    parameter int N = FRAME_N,
    parameter int K = MSG_K,
    parameter int W = CHK_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_check,
    output logic         out_zero,
    output logic         busy,
    output logic [15:0]  frame_cnt
);

    localparam int CNT_W = $clog2(N);

    // The register width is fixed; K only needs to be a sensible message length.
    if (W != CHK_W || N < 2 || K < 1 || K >= N) begin : g_param_err
        $error("chk_frame_seq: unsupported parameter set");
    end

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               clr, shift, frame_inc;
    logic [CHK_W-1:0]   check_q;

    chk_shift15 u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .shift   (shift),
        .data_in (in_bit),
        .q       (check_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Abort pre-empts every handshake, including a result being taken this cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr        = 1'b0;
        shift      = 1'b0;
        frame_inc  = 1'b0;
        if (abort) begin
            state_next = IDLE;
            cnt_next   = '0;
            clr        = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift      = 1'b1;
                        cnt_next   = CNT_W'(1);
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (in_valid) begin
                        shift = 1'b1;
                        if (cnt == CNT_W'(N - 1)) begin
                            cnt_next   = '0;
                            state_next = DONE;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        clr        = 1'b1;
                        frame_inc  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    clr        = 1'b1;
                end
            endcase
        end
    end

    // Handshake outputs come from state alone so in_ready never depends on in_valid/out_ready.
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);
    assign out_check = check_q;
    assign out_zero  = (out_check == '0);

endmodule

// File: tb/tb_chk_frame_seq.sv
// Scoreboard bench for chk_frame_seq: directed frames with hand-computed check values.
module tb_chk_frame_seq;

    localparam int N = 64;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_check;
    logic        out_zero;
    logic        busy;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [14:0] chk;
        logic [15:0] fc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model_fc = 16'd0;

    chk_frame_seq #(.N(64), .K(40), .W(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_check (out_check),
        .out_zero  (out_zero),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every result handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none at %0t", out_check, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_check", {17'd0, out_check}, {17'd0, e.chk});
                chk("out_zero", {31'd0, out_zero}, {31'd0, (e.chk == 15'd0)});
                chk("frame_cnt_at_hs", {16'd0, frame_cnt}, {16'd0, e.fc});
            end
        end
    end

    task automatic put_bit(input logic b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] bits, input logic [14:0] expv, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            put_bit(bits[i]);
        end
        exp_q.push_back({expv, model_fc});
        model_fc = model_fc + 16'd1;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(posedge clk);
        #1;
        while (out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (out_valid) chk("result_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_check", {17'd0, out_check}, 32'd0);
        chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain frames with known signatures.
        send_frame(64'h0, 15'h0000, 1'b0);
        wait_done();
        chk("frame_cnt_after_first", {16'd0, frame_cnt}, 32'd1);
        send_frame(64'h1, 15'h0800, 1'b0);
        wait_done();
        send_frame(64'h8000_0000_0000_0000, 15'h4000, 1'b0);
        wait_done();
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 15'h7800, 1'b0);
        wait_done();

        // Gapped input with the consumer stalling the result.
        out_ready = 1'b0;
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 15'h7800, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_out_check", {17'd0, out_check}, 32'h7800);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        send_frame(64'h0, 15'h0000, 1'b0);
        wait_done();

        // Abort partway through an all-ones frame.
        for (int i = 0; i < 30; i++) put_bit(1'b1);
        abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out_check", {17'd0, out_check}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 15'h7800, 1'b0);
        wait_done();
        chk("frame_cnt_after_abort", {16'd0, frame_cnt}, {16'd0, model_fc});

        // Abort on the same cycle as the result handshake: the result is dropped.
        out_ready = 1'b0;
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 15'h7800, 1'b0);
        void'(exp_q.pop_back());
        model_fc = model_fc - 16'd1;
        @(posedge clk);
        #1;
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_hs_frame_cnt", {16'd0, frame_cnt}, {16'd0, model_fc});
        chk("abort_hs_out_check", {17'd0, out_check}, 32'd0);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 20; i++) put_bit(1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_check", {17'd0, out_check}, 32'd0);
        chk("midrst_out_zero", {31'd0, out_zero}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        model_fc = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(64'h0, 15'h0000, 1'b0);
        wait_done();
        chk("frame_cnt_after_reset", {16'd0, frame_cnt}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
